rr_arbiter_8_way: RTL and testbench



---
 rtl/rr_arbiter_8_way_pkg.sv | 13 +
 rtl/rr_arbiter_8_way_if.sv | 31 +++
 rtl/or_8_way.sv | 9 +
 rtl/rr_arbiter_8_way_pick.sv | 46 ++++
 rtl/rr_arbiter_8_way.sv | 137 +++++++++++++
 tb/tb_rr_arbiter_8_way.sv | 234 +++++++++++++++++++++++
 6 files changed

// File: rtl/rr_arbiter_8_way_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ   = 8;
    localparam int IDX_W     = 3;
    localparam int TIMEOUT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter_8_way_if.sv
// Requester-bank / arbiter handshake bundle. The requester bank is the
// master (drives req); the arbiter is the slave (drives the grant side).
interface rr_arbiter_8_way_if;
    import arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic               busy;
    logic               timeout;

    modport master (
        output req,
        input  grant,
        input  grant_valid,
        input  grant_idx,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output grant_valid,
        output grant_idx,
        output busy,
        output timeout
    );

endinterface

// File: rtl/or_8_way.sv
// Library OR cell: reduces an 8-bit vector to a single "any bit set" flag.
module or_8_way (
    input  logic [7:0] i_in,
    output logic       o_out
);

    assign o_out = |i_in;

endmodule

// File: rtl/rr_arbiter_8_way_pick.sv
// Round-robin selector for 8 requesters. The request vector is rotated so
// that bit ptr lands at position 0, a fixed lowest-bit-first priority
// encoder picks the winner, and the one-hot result is rotated back.
module rr_pick_8 (
    input  logic [7:0] i_req,
    input  logic [2:0] i_ptr,
    output logic [7:0] o_pick,
    output logic [2:0] o_idx,
    output logic       o_found
);

    logic [15:0] w_reqDbl;
    logic [3:0]  w_rotBase;
    logic [7:0]  w_rot;
    logic [2:0]  w_pos;
    logic        w_hit;
    logic [7:0]  w_rotHot;
    logic [15:0] w_hotDbl;
    logic [3:0]  w_backBase;

    assign w_reqDbl  = {i_req, i_req};
    assign w_rotBase = {1'b0, i_ptr};
    assign w_rot     = w_reqDbl[w_rotBase +: 8];

    // Fixed priority in the rotated domain: the lowest set bit is the one
    // closest to ptr in scan order, so the loop lets lower bits overwrite.
    always_comb begin
        w_pos = '0;
        w_hit = 1'b0;
        for (int j = 7; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_pos = 3'(j);
                w_hit = 1'b1;
            end
        end
    end

    assign w_rotHot   = w_hit ? (8'd1 << w_pos) : 8'd0;
    assign w_hotDbl   = {w_rotHot, w_rotHot};
    assign w_backBase = 4'd8 - {1'b0, i_ptr};

    assign o_pick  = w_hotDbl[w_backBase +: 8];
    assign o_idx   = w_pos + i_ptr;
    assign o_found = w_hit;

endmodule

// File: rtl/rr_arbiter_8_way.sv
// 8-way round-robin arbiter with an IDLE/BUSY state machine and fully
// registered outputs. A grant is held until its requester drops req, and
// the pointer then moves to the requester after the one just served.
// Optional macro ARB_TIMEOUT_EN adds a per-grant BUSY cycle limit
// (TIMEOUT_CYCLES) that forces a release and pulses timeout.
module rr_arbiter_8_way
    import arb_pkg::*;
#(
    parameter int NUM_REQ        = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    rr_arbiter_8_way_if.slave bus
);

    if (NUM_REQ != arb_pkg::NUM_REQ) begin : g_badNumReq
        $error("rr_arbiter_8_way: NUM_REQ must be 8");
    end

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_badTimeout
        $error("rr_arbiter_8_way: TIMEOUT_CYCLES must be in 2..255");
    end

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [7:0]       r_grant;
    logic [IDX_W-1:0] r_grantIdx;
    logic             r_grantValid;
    logic             r_busy;

    logic             w_anyReq;
    logic [7:0]       w_pick;
    logic [IDX_W-1:0] w_pickIdx;
    logic             w_found;
    logic             w_start;
    logic             w_held;
    logic             w_expire;
    logic             w_release;

    or_8_way u_anyReq (
        .i_in  (bus.req),
        .o_out (w_anyReq)
    );

    rr_pick_8 u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_idx   (w_pickIdx),
        .o_found (w_found)
    );

    assign w_start = w_anyReq & w_found;
    assign w_held  = bus.req[r_grantIdx];

`ifdef ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] r_count;
    logic                 r_timeout;

    assign w_expire = w_held && (r_count == TIMEOUT_LAST);
`else
    assign w_expire = 1'b0;
`endif

    // A normal release (req dropped) takes precedence over a forced one,
    // which is why w_expire already requires the request to be held.
    assign w_release = !w_held || w_expire;

    // Arbitration state machine: grant on entry to BUSY, release back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_grantIdx   <= '0;
            r_grantValid <= 1'b0;
            r_busy       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_count      <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state      <= BUSY;
                        r_grant      <= w_pick;
                        r_grantIdx   <= w_pickIdx;
                        r_grantValid <= 1'b1;
                        r_busy       <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        r_count      <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        r_state      <= IDLE;
                        r_ptr        <= r_grantIdx + 3'd1;
                        r_grant      <= '0;
                        r_grantIdx   <= '0;
                        r_grantValid <= 1'b0;
                        r_busy       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                        r_timeout    <= w_expire;
`endif
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        r_count <= r_count + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_valid = r_grantValid;
    assign bus.grant_idx   = r_grantIdx;
    assign bus.busy        = r_busy;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout     = r_timeout;
`else
    assign bus.timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8_way.sv
// Self-checking bench for rr_arbiter_8_way. A behavioural reference model
// predicts the registered outputs for every driven cycle and queues them;
// the queue is drained one entry per clock after the DUT updates. Directed
// constant checks cover the reset, rotation, skip/wrap, mid-grant reset and
// timeout scenarios, and per-cycle invariants run on the falling edge.
module tb_rr_arbiter_8_way;

    localparam int TO_CYCLES = 4;

    typedef struct packed {
        logic [7:0] grant;
        logic       valid;
        logic [2:0] idx;
        logic       busy;
        logic       timeout;
    } expect_t;

    logic    clk = 1'b0;
    logic    rst;
    int      vectorsApplied = 0;
    int      miscompares    = 0;
    expect_t expQ[$];
    logic    checkersOn = 1'b0;

    logic       mBusy;
    logic [2:0] mPtr;
    logic [2:0] mIdx;
    logic [7:0] mGrant;
    logic       mTimeout;
    int         mCount;

    rr_arbiter_8_way_if arbIf ();

    rr_arbiter_8_way #(
        .NUM_REQ        (8),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (arbIf)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectorsApplied++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelRelease();
        mPtr   = 3'(mIdx + 3'd1);
        mBusy  = 1'b0;
        mGrant = 8'h00;
        mIdx   = 3'd0;
    endtask

    // Reference behaviour: what the outputs must be after the next edge.
    task automatic modelStep(input logic rstV, input logic [7:0] reqV);
        bit found;
        int j;
        mTimeout = 1'b0;
        if (rstV) begin
            mBusy  = 1'b0;
            mGrant = 8'h00;
            mIdx   = 3'd0;
            mPtr   = 3'd0;
            mCount = 0;
        end else if (!mBusy) begin
            found = 0;
            for (int k = 0; k < 8; k++) begin
                j = (int'(mPtr) + k) % 8;
                if (!found && reqV[j]) begin
                    found = 1;
                    mIdx  = 3'(j);
                end
            end
            if (found) begin
                mBusy  = 1'b1;
                mGrant = 8'd1 << mIdx;
                mCount = 0;
            end
        end else begin
            if (!reqV[mIdx]) begin
                modelRelease();
            end
`ifdef ARB_TIMEOUT_EN
            else if (mCount == TO_CYCLES - 1) begin
                modelRelease();
                mTimeout = 1'b1;
            end else begin
                mCount++;
            end
`endif
        end
    endtask

    task automatic checkOutput(input string label);
        expect_t e;
        if (expQ.size() == 0) begin
            checkValue({label, ".queue_empty"}, 8'h01, 8'h00);
        end else begin
            e = expQ.pop_front();
            checkValue({label, ".grant"},   arbIf.grant,                e.grant);
            checkValue({label, ".valid"},   {7'd0, arbIf.grant_valid},  {7'd0, e.valid});
            checkValue({label, ".idx"},     {5'd0, arbIf.grant_idx},    {5'd0, e.idx});
            checkValue({label, ".busy"},    {7'd0, arbIf.busy},         {7'd0, e.busy});
            checkValue({label, ".timeout"}, {7'd0, arbIf.timeout},      {7'd0, e.timeout});
        end
    endtask

    task automatic applyStimulus(input string label, input logic rstV, input logic [7:0] reqV);
        rst       = rstV;
        arbIf.req = reqV;
        modelStep(rstV, reqV);
        expQ.push_back('{grant: mGrant, valid: mBusy, idx: mIdx, busy: mBusy, timeout: mTimeout});
        @(posedge clk);
        #1;
        checkOutput(label);
    endtask

    // Structural invariants sampled mid-cycle once outputs are defined.
    always @(negedge clk) begin
        if (checkersOn) begin
            vectorsApplied++;
            assert ($onehot0(arbIf.grant)) else begin
                miscompares++;
                $error("[TB] FAIL inv_onehot observed=%h expected=zero_or_onehot", arbIf.grant);
            end
            vectorsApplied++;
            assert (arbIf.grant_valid === (|arbIf.grant)) else begin
                miscompares++;
                $error("[TB] FAIL inv_valid observed=%b expected=%b", arbIf.grant_valid, |arbIf.grant);
            end
            vectorsApplied++;
            assert (arbIf.busy === arbIf.grant_valid) else begin
                miscompares++;
                $error("[TB] FAIL inv_busy observed=%b expected=%b", arbIf.busy, arbIf.grant_valid);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        arbIf.req = 8'hFF;
        mBusy = 1'b0; mPtr = 3'd0; mIdx = 3'd0; mGrant = 8'h00; mTimeout = 1'b0; mCount = 0;

        // Reset held two cycles with every requester active.
        applyStimulus("rst0", 1'b1, 8'hFF);
        checkersOn = 1'b1;
        checkValue("rst0_grant", arbIf.grant, 8'h00);
        checkValue("rst0_busy", {7'd0, arbIf.busy}, 8'h00);
        applyStimulus("rst1", 1'b1, 8'hFF);
        checkValue("rst1_grant", arbIf.grant, 8'h00);
        applyStimulus("first", 1'b0, 8'hFF);
        checkValue("first_grant", arbIf.grant, 8'h01);
        checkValue("first_idx", {5'd0, arbIf.grant_idx}, 8'h00);

        // Rotation: two grant cycles, one-cycle drop, then next requester.
        for (int g = 0; g < 8; g++) begin
            applyStimulus("rot_hold", 1'b0, 8'hFF);
            checkValue("rot_hold_grant", arbIf.grant, 8'(1 << g));
            applyStimulus("rot_drop", 1'b0, 8'hFF & ~(8'd1 << g));
            checkValue("rot_idle", arbIf.grant, 8'h00);
            applyStimulus("rot_regrant", 1'b0, 8'hFF);
            checkValue("rot_idx", {5'd0, arbIf.grant_idx}, 8'((g + 1) % 8));
        end
        applyStimulus("rot_end", 1'b0, 8'h00);

        // Single requester held five cycles, then the pointer sits at 5.
        for (int i = 0; i < 5; i++) begin
            applyStimulus("single", 1'b0, 8'h10);
            checkValue("single_grant", arbIf.grant, 8'h10);
        end
        applyStimulus("single_drop", 1'b0, 8'h00);
        checkValue("single_drop_grant", arbIf.grant, 8'h00);
        applyStimulus("single_next", 1'b0, 8'hFF);
        checkValue("single_next_idx", {5'd0, arbIf.grant_idx}, 8'h05);

        // Skip and wrap from pointer 6.
        applyStimulus("skip_rel", 1'b0, 8'h00);
        applyStimulus("skip_pick", 1'b0, 8'h05);
        checkValue("skip_pick_idx", {5'd0, arbIf.grant_idx}, 8'h00);
        applyStimulus("skip_rel2", 1'b0, 8'h04);
        checkValue("skip_rel2_grant", arbIf.grant, 8'h00);
        applyStimulus("skip_next", 1'b0, 8'h05);
        checkValue("skip_next_idx", {5'd0, arbIf.grant_idx}, 8'h02);

        // Reset pulse in the middle of a grant.
        applyStimulus("mid_rel", 1'b0, 8'h00);
        applyStimulus("mid_grant", 1'b0, 8'h08);
        checkValue("mid_grant_grant", arbIf.grant, 8'h08);
        applyStimulus("mid_rst", 1'b1, 8'h0A);
        checkValue("mid_rst_grant", arbIf.grant, 8'h00);
        applyStimulus("mid_after", 1'b0, 8'h0A);
        checkValue("mid_after_idx", {5'd0, arbIf.grant_idx}, 8'h01);
        applyStimulus("mid_end", 1'b0, 8'h00);

        // Single requester held for a long stretch.
        for (int i = 1; i <= 20; i++) begin
            applyStimulus("to_hold", 1'b0, 8'h02);
`ifdef ARB_TIMEOUT_EN
            checkValue("to_grant", arbIf.grant, (i % 5 == 0) ? 8'h00 : 8'h02);
            checkValue("to_pulse", {7'd0, arbIf.timeout}, (i % 5 == 0) ? 8'h01 : 8'h00);
`else
            checkValue("to_grant", arbIf.grant, 8'h02);
            checkValue("to_pulse", {7'd0, arbIf.timeout}, 8'h00);
`endif
        end

        // Release on the same cycle the limit would expire: no timeout pulse.
        applyStimulus("tie_rel", 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("tie_hold", 1'b0, 8'h02);
        end
        applyStimulus("tie_drop", 1'b0, 8'h00);
        checkValue("tie_grant", arbIf.grant, 8'h00);
        checkValue("tie_pulse", {7'd0, arbIf.timeout}, 8'h00);

        // Random traffic with occasional resets, checked against the model.
        for (int i = 0; i < 120; i++) begin
            applyStimulus("rand", ($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)));
        end

        checkersOn = 1'b0;
        checkValue("queue_drained", 8'(expQ.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
